// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: configurable data width, parity and stop bits.
// Frames are streamed back-to-back while the FIFO holds words.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 10417,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic                                flush,
  input  logic [DATA_BITS-1:0]                in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                TX,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;

  state_e               state_q;
  logic [CW-1:0]        baud_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 done_q;

  logic                 push;
  logic                 pop;
  logic                 last_stop;
  logic                 stop_end;
  logic [DATA_BITS-1:0] head;

  // in_ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
  assign in_ready  = (level_q != LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign stop_end  = (state_q == S_STOP) && (baud_q == '0) && last_stop;
  assign pop       = (level_q != '0) && ((state_q == S_IDLE) || stop_end);
  assign head      = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      baud_q  <= BAUD_LOAD;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      baud_q  <= BAUD_LOAD;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // done is raised one cycle early so it sits on the final stop-bit cycle.
      done_q <= (state_q == S_STOP) && last_stop && (baud_q == CW'(1));
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            par_q   <= (PARITY == 2) ? ~^head : ^head;
            tx_q    <= 1'b0;
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_LOAD;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - CW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LOAD;
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + BW'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - CW'(1);
          end
        end
        S_PARITY: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - CW'(1);
          end
        end
        S_STOP: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LOAD;
            if (!last_stop) begin
              bit_q <= bit_q + BW'(1);
            end else if (pop) begin
              shift_q <= head;
              par_q   <= (PARITY == 2) ? ~^head : ^head;
              tx_q    <= 1'b0;
              bit_q   <= '0;
              state_q <= S_START;
            end else begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - CW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TX    = tx_q;
  assign done  = done_q;
  assign level = level_q;
  assign busy  = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 7N2) share one stimulus stream
// and are compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int N     = 4;
  localparam int DB  [N] = '{8, 8, 8, 7};
  localparam int PAR [N] = '{0, 1, 2, 0};
  localparam int SB  [N] = '{1, 1, 1, 2};

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic [N-1:0] tx_w, busy_w, done_w, rdy_w;
  logic [2:0]   lvl_w [N];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_fifo #(
      .BAUD_DIV  (BAUD),
      .DATA_BITS (DB[g]),
      .PARITY    (PAR[g]),
      .STOP_BITS (SB[g]),
      .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk     (clk),
      .arst    (arst),
      .flush   (flush),
      .in_data (in_data[DB[g]-1:0]),
      .in_valid(in_valid),
      .in_ready(rdy_w[g]),
      .TX      (tx_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .level   (lvl_w[g])
    );
  end

  // Reference model: a word queue plus the bit pattern of the frame on the wire.
  logic [7:0]  mfifo [N][DEPTH];
  int          mcnt [N];
  int          mrd  [N];
  int          mwr  [N];
  bit          mact [N];
  int          mpos [N];
  int          mlen [N];
  logic [15:0] mbits [N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0; mrd[i] = 0; mwr[i] = 0;
      mact[i] = 1'b0; mpos[i] = 0; mlen[i] = BAUD; mbits[i] = '1;
    end
  endtask

  task automatic build_frame(input int i, input logic [7:0] w);
    int  n;
    logic p;
    mbits[i]    = '1;
    mbits[i][0] = 1'b0;
    n = 1;
    for (int k = 0; k < DB[i]; k++) begin
      mbits[i][n] = w[k];
      n++;
    end
    if (PAR[i] != 0) begin
      p = 1'b0;
      for (int k = 0; k < DB[i]; k++) p = p ^ w[k];
      if (PAR[i] == 2) p = ~p;
      mbits[i][n] = p;
      n++;
    end
    n = n + SB[i];
    mlen[i] = n * BAUD;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit do_push;
      bit last;
      bit do_pop;
      do_push = in_valid && (mcnt[i] < DEPTH);
      last    = mact[i] && (mpos[i] == mlen[i] - 1);
      do_pop  = (mcnt[i] != 0) && (!mact[i] || last);
      if (mact[i]) begin
        if (last) mact[i] = 1'b0;
        else      mpos[i] = mpos[i] + 1;
      end
      if (do_pop) begin
        build_frame(i, mfifo[i][mrd[i]]);
        mrd[i]  = (mrd[i] + 1) % DEPTH;
        mcnt[i] = mcnt[i] - 1;
        mact[i] = 1'b1;
        mpos[i] = 0;
      end
      if (do_push) begin
        mfifo[i][mwr[i]] = in_data & 8'((1 << DB[i]) - 1);
        mwr[i]  = (mwr[i] + 1) % DEPTH;
        mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge arst);
      if (arst || flush) model_clear();
      else               model_step();
    end
  end

  // Every falling edge: all outputs of all instances against the model.
  initial begin
    logic       etx, edone, ebusy, erdy;
    logic [2:0] elvl;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        etx   = mact[i] ? mbits[i][mpos[i] / BAUD] : 1'b1;
        edone = mact[i] && (mpos[i] == mlen[i] - 1);
        ebusy = mact[i] || (mcnt[i] != 0);
        erdy  = (mcnt[i] < DEPTH);
        elvl  = 3'(mcnt[i]);
        n_vec++;
        if ({tx_w[i], done_w[i], busy_w[i], rdy_w[i], lvl_w[i]} !== {etx, edone, ebusy, erdy, elvl}) begin
          n_err++;
          $display("FAIL model_cmp inst%0d t=%0t tx/done/busy/rdy=%b%b%b%b level=%0d, expected %b%b%b%b level=%0d",
                   i, $time, tx_w[i], done_w[i], busy_w[i], rdy_w[i], lvl_w[i], etx, edone, ebusy, erdy, elvl);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  function automatic logic [39:0] frame_8n1(input logic [7:0] w);
    logic [9:0]  b;
    logic [39:0] f;
    b = {1'b1, w, 1'b0};
    for (int c = 0; c < 40; c++) f[c] = b[c / BAUD];
    return f;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_w != '0) && (k < 1000)) begin
      tick(1);
      k++;
    end
    n_vec++;
    if (busy_w != '0) begin
      n_err++;
      $display("FAIL wait_idle busy=%b after %0d cycles, expected 0000", busy_w, k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({tx_w[i], busy_w[i], done_w[i], rdy_w[i], lvl_w[i]} !== {4'b1001, 3'd0}) begin
        n_err++;
        $display("FAIL %s inst%0d tx/busy/done/rdy=%b%b%b%b level=%0d, expected 1001 level=0",
                 tag, i, tx_w[i], busy_w[i], done_w[i], rdy_w[i], lvl_w[i]);
      end
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    tick(2);
    check_reset_outputs("reset_held");
    arst = 1'b0;
    tick(2);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_8n1();
    int          seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [39:0] cap, exp;
    int          done_n, done_c;
    done_n = 0; done_c = 0;
    wait_idle();
    push1(8'hA5);
    for (int c = 0; c < 40; c++) begin
      exp[c] = seq[c / BAUD][0];
      tick(1);
      cap[c] = tx_w[0];
      if (done_w[0]) begin done_n++; done_c = c + 1; end
    end
    n_vec++;
    if (cap !== exp) begin
      n_err++;
      $display("FAIL 8n1_tx got %h expected %h", cap, exp);
    end
    n_vec++;
    if (done_n != 1 || done_c != 40) begin
      n_err++;
      $display("FAIL 8n1_done pulses=%0d at cycle %0d, expected 1 at cycle 40", done_n, done_c);
    end
    tick(1);
    n_vec++;
    if (busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL 8n1_busy_after got %b expected 0", busy_w[0]);
    end
  endtask

  task automatic test_parity();
    logic [3:0] pe, po;
    int         de, dod;
    de = 0; dod = 0;
    wait_idle();
    push1(8'h07);
    for (int c = 1; c <= 44; c++) begin
      tick(1);
      if (c >= 37 && c <= 40) begin
        pe[c - 37] = tx_w[1];
        po[c - 37] = tx_w[2];
      end
      if (done_w[1]) de = c;
      if (done_w[2]) dod = c;
    end
    n_vec++;
    if (pe !== 4'b1111) begin
      n_err++;
      $display("FAIL parity_even bit got %b expected 1111", pe);
    end
    n_vec++;
    if (po !== 4'b0000) begin
      n_err++;
      $display("FAIL parity_odd bit got %b expected 0000", po);
    end
    n_vec++;
    if (de != 44 || dod != 44) begin
      n_err++;
      $display("FAIL parity_frame_len done at %0d/%0d expected 44/44", de, dod);
    end
  endtask

  task automatic test_7n2();
    int          seq [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [39:0] cap, exp;
    int          done_n, done_c;
    done_n = 0; done_c = 0;
    wait_idle();
    push1(8'h41);
    for (int c = 0; c < 40; c++) begin
      exp[c] = seq[c / BAUD][0];
      tick(1);
      cap[c] = tx_w[3];
      if (done_w[3]) begin done_n++; done_c = c + 1; end
    end
    n_vec++;
    if (cap !== exp) begin
      n_err++;
      $display("FAIL 7n2_tx got %h expected %h", cap, exp);
    end
    n_vec++;
    if (done_n != 1 || done_c != 40) begin
      n_err++;
      $display("FAIL 7n2_done pulses=%0d at cycle %0d, expected 1 at cycle 40", done_n, done_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] rdy_seen;
    logic [2:0] lvl_at_refuse;
    int         done_n, idle_n;
    done_n = 0; idle_n = 0;
    wait_idle();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data     = 8'(8'h11 * (k + 1));
      rdy_seen[k] = rdy_w[0];
      if (k == 5) lvl_at_refuse = lvl_w[0];
      tick(1);
    end
    in_valid = 1'b0;
    n_vec++;
    if (rdy_seen !== 6'b011111) begin
      n_err++;
      $display("FAIL b2b_ready pattern got %b expected 011111", rdy_seen);
    end
    n_vec++;
    if (lvl_at_refuse !== 3'd4) begin
      n_err++;
      $display("FAIL b2b_full_level got %0d expected 4", lvl_at_refuse);
    end
    // First frame started at the second push edge; five 40-cycle frames end 195 cycles from here.
    for (int c = 0; c < 195; c++) begin
      tick(1);
      if (done_w[0])  done_n++;
      if (!busy_w[0]) idle_n++;
    end
    n_vec++;
    if (done_n != 5 || idle_n != 0) begin
      n_err++;
      $display("FAIL b2b_stream done=%0d idle_cycles=%0d, expected 5 and 0", done_n, idle_n);
    end
    tick(1);
    n_vec++;
    if (busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy_after got %b expected 0", busy_w[0]);
    end
  endtask

  task automatic test_flush();
    logic [39:0] cap;
    int          done_n;
    done_n = 0;
    wait_idle();
    in_valid = 1'b1;
    in_data = 8'hFF; tick(1);
    in_data = 8'h12; tick(1);
    in_data = 8'h34; tick(1);
    in_valid = 1'b0;
    tick(14);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check_reset_outputs("flush_state");
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (done_w != '0) done_n++;
    end
    n_vec++;
    if (done_n != 0) begin
      n_err++;
      $display("FAIL flush_no_done got %0d done cycles expected 0", done_n);
    end
    push1(8'h5A);
    for (int c = 0; c < 40; c++) begin
      tick(1);
      cap[c] = tx_w[0];
    end
    n_vec++;
    if (cap !== frame_8n1(8'h5A)) begin
      n_err++;
      $display("FAIL flush_next_frame got %h expected %h", cap, frame_8n1(8'h5A));
    end
  endtask

  task automatic test_arst_mid_stop();
    logic [39:0] cap;
    wait_idle();
    push1(8'h81);
    tick(37);
    #3;
    arst = 1'b1;
    #1;
    check_reset_outputs("arst_async");
    tick(1);
    arst = 1'b0;
    tick(1);
    push1(8'h3C);
    for (int c = 0; c < 40; c++) begin
      tick(1);
      cap[c] = tx_w[0];
    end
    n_vec++;
    if (cap !== frame_8n1(8'h3C)) begin
      n_err++;
      $display("FAIL arst_next_frame got %h expected %h", cap, frame_8n1(8'h3C));
    end
  endtask

  task automatic test_random();
    wait_idle();
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_flush();
    test_arst_mid_stop();
    test_random();
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
